// File: rtl/csr_issue_if.sv
// Purpose: bundles the handshakes around the CSR issue block: instruction
//          intake, CSR file request/response, writeback and exception report.
// Ports:   slave = view of csr_issue itself; master = view of the pipeline/CSR file around it.
interface csr_issue_if #(
    parameter int XLEN = 32
);
    // Decoded CSR instruction from the issue stage
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [11:0]     in_addr;
    logic [XLEN-1:0] in_src;
    logic            in_src_zero;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    // Request/response to the CSR file
    logic            csr_req_valid;
    logic            csr_req_ready;
    logic [11:0]     csr_req_a;
    logic [1:0]      csr_req_t;
    logic [XLEN-1:0] csr_req_d;
    logic [XLEN-1:0] csr_resp_d;
    logic            csr_resp_exists;

    // Register writeback
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // Exception report
    logic            exc_valid;
    logic [XLEN-1:0] exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;

    modport slave (
        input  in_valid, in_op, in_addr, in_src, in_src_zero, in_rd, in_pc, flush,
        input  csr_req_ready, csr_resp_d, csr_resp_exists, wb_ready,
        output in_ready, csr_req_valid, csr_req_a, csr_req_t, csr_req_d,
        output wb_valid, wb_rd, wb_data,
        output exc_valid, exc_cause, exc_pc, exc_tval
    );

    modport master (
        output in_valid, in_op, in_addr, in_src, in_src_zero, in_rd, in_pc, flush,
        output csr_req_ready, csr_resp_d, csr_resp_exists, wb_ready,
        input  in_ready, csr_req_valid, csr_req_a, csr_req_t, csr_req_d,
        input  wb_valid, wb_rd, wb_data,
        input  exc_valid, exc_cause, exc_pc, exc_tval
    );
endinterface

// File: rtl/csr_issue.sv
// Purpose: issues one decoded CSR instruction at a time to the CSR file and
//          returns the old value to the register file or raises an illegal-access exception.
// Ports:   clk, rst (async, active-high), bus (csr_issue_if.slave). Latency: 1 cycle
//          intake->request, responder wait, 1+ cycle writeback; in_ready only in IDLE,
//          request and writeback held until their ready.
module csr_issue #(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CAUSE = 2
) (
    input  logic         clk,
    input  logic         rst,
    csr_issue_if.slave   bus
);

    localparam logic [1:0] OP_CSRW = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_EXC
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_req_valid;
    logic            r_wb_valid;
    logic            r_exc_valid;
    logic            r_kill;
    logic [1:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_req_d;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_wb_data;
    logic [XLEN-1:0] r_exc_cause;

    logic            w_accept;
    logic            w_wr_intent;
    logic            w_illegal;
    logic            w_req_hs;
    logic            w_killed;

    assign w_accept    = bus.in_valid & ~bus.flush;
    // CSRS/CSRC with a zero source are reads only; CSRW always writes.
    assign w_wr_intent = (bus.in_op == OP_CSRW) | ~bus.in_src_zero;
    // Read-only address space written: evaluated on the incoming fields, which are
    // exactly what gets latched this cycle, so the decision lands with the latch.
    assign w_illegal   = (bus.in_addr[11:10] == 2'b11) & w_wr_intent;
    assign w_req_hs    = r_req_valid & bus.csr_req_ready;
    // A flush coinciding with the handshake cycle kills the result as well.
    assign w_killed    = r_kill | bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_req_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            r_kill      <= 1'b0;
            r_op        <= '0;
            r_addr      <= '0;
            r_req_d     <= '0;
            r_rd        <= '0;
            r_pc        <= '0;
            r_wb_data   <= '0;
            r_exc_cause <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.in_op;
                        r_addr     <= bus.in_addr;
                        r_rd       <= bus.in_rd;
                        r_pc       <= bus.in_pc;
                        // No write intent still issues, with a zero operand.
                        r_req_d    <= w_wr_intent ? bus.in_src : '0;
                        r_kill     <= 1'b0;
                        r_in_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state     <= S_EXC;
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= XLEN'(ILLEGAL_CAUSE);
                        end else begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // The request is never withdrawn; flush only marks the result dead.
                    if (w_req_hs) begin
                        r_req_valid <= 1'b0;
                        if (w_killed) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end else if (!bus.csr_resp_exists) begin
                            r_state     <= S_EXC;
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= XLEN'(ILLEGAL_CAUSE);
                        end else if (r_rd != 5'd0) begin
                            r_state    <= S_WB;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= bus.csr_resp_d;
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        r_kill <= 1'b1;
                    end
                end
                S_WB: begin
                    if (bus.flush || bus.wb_ready) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                S_EXC: begin
                    r_state     <= S_IDLE;
                    r_exc_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_req_valid <= 1'b0;
                    r_wb_valid  <= 1'b0;
                    r_exc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.csr_req_valid = r_req_valid;
    assign bus.csr_req_a     = r_addr;
    assign bus.csr_req_t     = r_op;
    assign bus.csr_req_d     = r_req_d;
    // Flush suppresses a pending writeback/exception in the same cycle.
    assign bus.wb_valid      = r_wb_valid & ~bus.flush;
    assign bus.wb_rd         = r_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.exc_valid     = r_exc_valid & ~bus.flush;
    assign bus.exc_cause     = r_exc_cause;
    assign bus.exc_pc        = r_pc;
    assign bus.exc_tval      = {{(XLEN-12){1'b0}}, r_addr};

endmodule
